// File: rtl/vmm_result_sink_pkg.sv
// Shared VMM output-phase constants: result width, frame geometry, sink FSM encoding.
// No logic; imported by the sink and by VMM_CTL output sizing.
// Encodings are fixed so waveforms read the same across blocks.
package vmm_result_sink_pkg;

  localparam int VMM_DW   = 16;
  localparam int VMM_ROWS = 3;
  localparam int VMM_COLS = 4;

  typedef enum logic [1:0] {
    CAP   = 2'd0,
    ACK   = 2'd1,
    DRAIN = 2'd2
  } sink_state_e;

  // Index width for an n-entry buffer; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmm_result_sink_buf.sv
// vmm_res_buf: NWORDS x DW frame register file, one write port, one async read port.
// Latency: write lands on the next clk edge; read is combinational from raddr.
// Backpressure: none; the owning FSM decides when writes and reads are meaningful.
module vmm_res_buf #(
  parameter int DW     = 16,
  parameter int NWORDS = 12,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Storage is deliberately unreset: contents are only read after a full frame is written.
  logic [DW-1:0] mem_q [NWORDS];

  // Capture one result word per write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vmm_result_sink.sv
// Collects one VMM result frame word by word (next_o/done_i), then streams it out with m_last.
// Latency: done_i one cycle after next_o is seen in CAP; first m_valid one cycle after the last done_i.
// Backpressure: while draining, done_i is withheld so the VMM stalls; m_ready may stall the drain forever.
module vmm_result_sink
  import vmm_result_sink_pkg::*;
#(
  parameter int DW   = VMM_DW,
  parameter int ROWS = VMM_ROWS,
  parameter int COLS = VMM_COLS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          next_o,
  input  logic [DW-1:0] o_data,
  output logic          done_i,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic [7:0]    frame_cnt
);

  localparam int NWORDS = ROWS * COLS;
  localparam int AW     = idx_width(NWORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NWORDS - 1);

  sink_state_e   state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          buf_we;
  logic [DW-1:0] buf_rdata;

  vmm_res_buf #(
    .DW    (DW),
    .NWORDS(NWORDS),
    .AW    (AW)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(wr_idx_q),
    .wdata(o_data),
    .raddr(rd_idx_q),
    .rdata(buf_rdata)
  );

  // State and counter registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CAP;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state: capture in CAP, acknowledge in ACK (next_o still high there, so no capture), drain in DRAIN.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    frame_cnt_d = frame_cnt_q;
    buf_we      = 1'b0;
    case (state_q)
      CAP: begin
        if (next_o) begin
          buf_we  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (wr_idx_q == LAST_IDX) begin
          wr_idx_d = '0;
          rd_idx_d = '0;
          state_d  = DRAIN;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
          state_d  = CAP;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d    = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = CAP;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = CAP;
      end
    endcase
  end

  // Outputs decode registered state only, so m_data holds steady across a stall.
  always_comb begin
    done_i    = (state_q == ACK);
    busy      = (state_q == DRAIN);
    m_valid   = busy;
    m_last    = busy && (rd_idx_q == LAST_IDX);
    m_data    = busy ? buf_rdata : '0;
    frame_cnt = frame_cnt_q;
  end

endmodule

// File: tb/tb_vmm_result_sink.sv
module tb_vmm_result_sink;

  localparam int NW = 12;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        next_o;
  logic [15:0] o_data;
  logic        done_i;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [15:0] partial[$];
  logic [7:0]  exp_frames = 8'd0;
  int          frames_seen = 0;
  int          rmode = 0;

  vmm_result_sink dut (
    .clk      (clk),
    .rst      (rst),
    .next_o   (next_o),
    .o_data   (o_data),
    .done_i   (done_i),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every acknowledged word joins the open frame; a full frame
  // of NW words becomes the expected output sequence, last flag on the final one.
  task automatic note_ack(input logic [15:0] v);
    partial.push_back(v);
    if (partial.size() == NW) begin
      for (int i = 0; i < NW; i++) begin
        exp_t e;
        e.data = partial[i];
        e.last = (i == NW - 1);
        exp_q.push_back(e);
      end
      partial.delete();
    end
  endtask

  // Downstream ready pattern generator.
  int pat = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: begin m_ready = (pat == 0); pat = (pat + 1) % 3; end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: checks the stream against the scoreboard and handshake rules.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_done  = 1'b0;
  logic [15:0] prev_data  = '0;
  logic        prev_last  = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      chk(frame_cnt == exp_frames, "frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      if (done_i) begin
        chk(!prev_done, "done_single_cycle", 32'(prev_done), 32'd0);
        chk(!busy, "done_during_drain", 32'(busy), 32'd0);
      end
      if (m_valid) chk(busy, "busy_with_valid", 32'(busy), 32'd1);
      if (prev_valid && !prev_ready && m_valid) begin
        chk(m_data == prev_data, "stall_data_stable", 32'(m_data), 32'(prev_data));
        chk(m_last == prev_last, "stall_last_stable", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", 32'(m_data), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(m_data == e.data, "m_data", 32'(m_data), 32'(e.data));
          chk(m_last == e.last, "m_last", 32'(m_last), 32'(e.last));
          if (e.last) begin
            exp_frames = exp_frames + 8'd1;
            frames_seen++;
          end
        end
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_done  = done_i;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst    = 1'b1;
    next_o = 1'b0;
    exp_q.delete();
    partial.delete();
    exp_frames  = 8'd0;
    frames_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk(done_i == 1'b0,     "rst_done_i",    32'(done_i),    32'd0);
    chk(m_valid == 1'b0,    "rst_m_valid",   32'(m_valid),   32'd0);
    chk(m_last == 1'b0,     "rst_m_last",    32'(m_last),    32'd0);
    chk(busy == 1'b0,       "rst_busy",      32'(busy),      32'd0);
    chk(frame_cnt == 8'd0,  "rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk(m_data == 16'd0,    "rst_m_data",    32'(m_data),    32'd0);
  endtask

  // Wait for the acknowledge of the word currently offered; returns at posedge+1.
  task automatic wait_ack(input logic [15:0] v);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (done_i) break;
      t++;
      if (t > 1000) begin
        chk(1'b0, "ack_timeout", 32'(t), 32'd1000);
        break;
      end
    end
    if (t <= 1000) note_ack(v);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [15:0] v);
    next_o = 1'b1;
    o_data = v;
    wait_ack(v);
  endtask

  task automatic send_frame(input bit rnd, input logic [15:0] base);
    for (int i = 0; i < NW; i++) begin
      if (rnd) send_word(16'($urandom));
      else     send_word(base + 16'(i));
    end
    next_o = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) chk(1'b0, "drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int dones;
    int k;
    rst    = 1'b1;
    next_o = 1'b0;
    o_data = '0;
    m_ready = 1'b0;

    // 1: reset state, then a simple frame 1..12 with m_ready high.
    rmode = 0;
    do_reset();
    send_frame(1'b0, 16'h0001);
    wait_drain();
    chk(frame_cnt == 8'd1, "t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // 2: next_o held high for 30 cycles while downstream is stalled.
    rmode  = 3;
    next_o = 1'b1;
    k      = 0;
    dones  = 0;
    o_data = 16'h2000;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_i) begin
        dones++;
        note_ack(o_data);
        k++;
      end
      @(posedge clk); #1;
      o_data = 16'h2000 + 16'(k);
    end
    next_o = 1'b0;
    chk(dones == NW, "t2_capture_count", 32'(dones), 32'(NW));
    chk(busy == 1'b1, "t2_busy_in_drain", 32'(busy), 32'd1);
    rmode = 0;
    wait_drain();

    // 3: m_ready pattern 1,0,0 during drain.
    rmode = 1;
    send_frame(1'b0, 16'h4000);
    wait_drain();

    // 4: offer a word for 20 cycles while drain is blocked; it must wait.
    rmode = 3;
    send_frame(1'b0, 16'h3000);
    next_o = 1'b1;
    o_data = 16'hDEAD;
    dones  = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_i) dones++;
    end
    @(posedge clk); #1;
    chk(dones == 0, "t4_no_done_while_busy", 32'(dones), 32'd0);
    chk(busy == 1'b1, "t4_busy_held", 32'(busy), 32'd1);
    rmode = 0;
    wait_ack(16'hDEAD);
    for (int i = 1; i < NW; i++) send_word(16'h3100 + 16'(i));
    next_o = 1'b0;
    wait_drain();

    // 5: reset after a partial frame, then a clean frame.
    for (int i = 0; i < 5; i++) send_word(16'h5500 + 16'(i));
    next_o = 1'b0;
    do_reset();
    send_frame(1'b0, 16'h5000);
    wait_drain();
    chk(frame_cnt == 8'd1, "t5_frame_cnt", 32'(frame_cnt), 32'd1);

    // 6: 256 random frames with random m_ready; counter wraps to zero.
    do_reset();
    rmode = 2;
    repeat (256) send_frame(1'b1, 16'h0);
    wait_drain();
    chk(frames_seen == 256, "t6_frames_drained", 32'(frames_seen), 32'd256);
    chk(frame_cnt == 8'd0, "t6_frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    chk(exp_q.size() == 0, "t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
